usr_reg_led_ctrl: RTL and testbench

//  Consumes the 16-bit software-written user register exported by the MCU and turns it into an LED drive pattern.

---
 rtl/usr_reg_led_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_usr_reg_led_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/usr_reg_led_ctrl.sv
// LED pattern generator driven by the MCU user register: OFF, PWM dim, blink, breathe.
// Optional macro BREATHE_EN builds the breathe engine; without it mode 11 behaves as ON.
module usr_reg_led_ctrl #(
    parameter int TICK_DIV      = 25000,
    parameter int PWM_PRESC     = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk25,
    input  logic        fpga_rst_n,
    input  logic [15:0] usr_reg,
    output logic        led_out,
    output logic        cfg_update,
    output logic [1:0]  mode_o
);

    localparam int PW = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(PWM_PRESC - 1);
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ACC  = SW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    logic [15:0]   shadow_r;
    logic [15:0]   active_r;
    logic [SW-1:0] stab_cnt_r;
    logic          cfg_update_r;
    logic [PW-1:0] presc_r;
    logic [5:0]    pwm_cnt_r;
    logic [TW-1:0] tick_cnt_r;
    logic [7:0]    blink_cnt_r;
    logic          phase_r;
    logic          led_out_r;

    logic          same_s;
    logic          accept_s;
    logic          presc_wrap_s;
    logic          tick_s;
    logic          step_s;
    logic [7:0]    hp_s;
    logic [5:0]    duty_s;
    mode_e         mode_s;

    function automatic logic pwm_on_f(input logic [5:0] lvl, input logic [5:0] cnt);
        return (lvl == 6'd63) ? 1'b1 : (cnt < lvl);
    endfunction

    assign same_s       = (usr_reg == shadow_r);
    assign accept_s     = same_s && (stab_cnt_r == STAB_ACC) && (shadow_r != active_r);
    assign presc_wrap_s = (presc_r == PRESC_MAX);
    assign tick_s       = (tick_cnt_r == TICK_MAX);
    assign hp_s         = (active_r[7:0] == 8'd0) ? 8'd1 : active_r[7:0];
    assign step_s       = tick_s && (blink_cnt_r == (hp_s - 8'd1));
    assign duty_s       = active_r[13:8];
    assign mode_s       = mode_e'(active_r[15:14]);

    assign led_out    = led_out_r;
    assign cfg_update = cfg_update_r;
    assign mode_o     = active_r[15:14];

    // Stability filter: a value must be seen STABLE_CYCLES+1 times in a row before it is adopted.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            shadow_r     <= 16'h0000;
            active_r     <= 16'h0000;
            stab_cnt_r   <= '0;
            cfg_update_r <= 1'b0;
        end else begin
            shadow_r     <= usr_reg;
            cfg_update_r <= accept_s;
            if (!same_s) begin
                stab_cnt_r <= '0;
            end else if (stab_cnt_r != STAB_MAX) begin
                stab_cnt_r <= stab_cnt_r + SW'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
            if (accept_s) begin
                active_r <= shadow_r;
            end else begin
                active_r <= active_r;
            end
        end
    end

    // Free-running PWM prescaler and 64-step frame counter.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            presc_r   <= '0;
            pwm_cnt_r <= 6'd0;
        end else if (presc_wrap_s) begin
            presc_r   <= '0;
            pwm_cnt_r <= pwm_cnt_r + 6'd1;
        end else begin
            presc_r   <= presc_r + PW'(1);
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Free-running timing tick divider.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Half-period tick counter and blink phase; a new configuration restarts lit.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            blink_cnt_r <= 8'd0;
            phase_r     <= 1'b0;
        end else if (accept_s) begin
            blink_cnt_r <= 8'd0;
            phase_r     <= 1'b1;
        end else if (step_s) begin
            blink_cnt_r <= 8'd0;
            phase_r     <= ~phase_r;
        end else if (tick_s) begin
            blink_cnt_r <= blink_cnt_r + 8'd1;
            phase_r     <= phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r;
            phase_r     <= phase_r;
        end
    end

`ifdef BREATHE_EN
    logic [5:0] blvl_r;
    logic       dir_up_r;

    // Breathe level walks a triangle 0..duty..0 one step per half-period.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            blvl_r   <= 6'd0;
            dir_up_r <= 1'b1;
        end else if (accept_s) begin
            blvl_r   <= 6'd0;
            dir_up_r <= 1'b1;
        end else if (step_s) begin
            if (duty_s == 6'd0) begin
                blvl_r   <= 6'd0;
                dir_up_r <= 1'b1;
            end else if (blvl_r > duty_s) begin
                blvl_r   <= duty_s;
                dir_up_r <= 1'b0;
            end else if (dir_up_r && (blvl_r != duty_s)) begin
                blvl_r   <= blvl_r + 6'd1;
                dir_up_r <= ((blvl_r + 6'd1) != duty_s);
            end else if (blvl_r == 6'd0) begin
                blvl_r   <= 6'd1;
                dir_up_r <= (duty_s != 6'd1);
            end else begin
                blvl_r   <= blvl_r - 6'd1;
                dir_up_r <= (blvl_r == 6'd1);
            end
        end else begin
            blvl_r   <= blvl_r;
            dir_up_r <= dir_up_r;
        end
    end
`endif

    // Mode FSM output stage: the LED is registered one cycle behind its condition.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            led_out_r <= 1'b0;
        end else begin
            case (mode_s)
                MODE_OFF:     led_out_r <= 1'b0;
                MODE_ON:      led_out_r <= pwm_on_f(duty_s, pwm_cnt_r);
                MODE_BLINK:   led_out_r <= phase_r & pwm_on_f(duty_s, pwm_cnt_r);
`ifdef BREATHE_EN
                MODE_BREATHE: led_out_r <= pwm_on_f(blvl_r, pwm_cnt_r);
`else
                MODE_BREATHE: led_out_r <= pwm_on_f(duty_s, pwm_cnt_r);
`endif
                default:      led_out_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_reg_led_ctrl.sv
// Scoreboard bench for usr_reg_led_ctrl: a cycle-count reference model predicts every output.
module tb_usr_reg_led_ctrl;

    localparam int TD = 10;
    localparam int P  = 1;
    localparam int S  = 4;

    logic        clk25 = 1'b0;
    logic        fpga_rst_n = 1'b1;
    logic [15:0] usr_reg = 16'h4000;
    logic        led_out;
    logic        cfg_update;
    logic [1:0]  mode_o;

    usr_reg_led_ctrl #(.TICK_DIV(TD), .PWM_PRESC(P), .STABLE_CYCLES(S)) dut (
        .clk25(clk25), .fpga_rst_n(fpga_rst_n), .usr_reg(usr_reg),
        .led_out(led_out), .cfg_update(cfg_update), .mode_o(mode_o)
    );

    // Free-running 25 MHz-style clock generator.
    always #10 clk25 = ~clk25;

    logic [3:0]  exp_q[$];
    logic [15:0] hist[$];
    logic [15:0] active_m;
    int          acc_m;
    int          n_m;
    logic        exp_led_m;
    int          n_tests = 0;
    int          n_fail = 0;

    // Level of a triangle wave 0..d..0 after k steps.
    function automatic int tri_lvl(input int k, input int d);
        int m;
        if (d == 0) return 0;
        m = k % (2 * d);
        return (m <= d) ? m : (2 * d - m);
    endfunction

    // Expected LED for the edge numbered n, given the configuration adopted at edge acc.
    function automatic logic led_ref(input logic [15:0] act, input int acc, input int n);
        int pc, hp, duty, t, k, lv;
        logic on;
        duty = int'(act[13:8]);
        hp   = (act[7:0] == 8'd0) ? 1 : int'(act[7:0]);
        pc   = ((n - 1) / P) % 64;
        t    = (n - 1) / TD - acc / TD;
        k    = t / hp;
        lv   = duty;
        on   = 1'b1;
        case (act[15:14])
            2'b00: on = 1'b0;
            2'b10: on = ((k % 2) == 0);
`ifdef BREATHE_EN
            2'b11: lv = tri_lvl(k, duty);
`endif
            default: on = 1'b1;
        endcase
        return on && ((lv == 63) || (pc < lv));
    endfunction

    // Direct check that asynchronous reset forces all outputs to their reset values.
    task automatic check_reset_state(input string tag);
        #1;
        n_tests++;
        if ({led_out, cfg_update, mode_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset state (%s): led/cfg/mode got %b/%b/%b expected 0/0/00",
                     tag, led_out, cfg_update, mode_o);
        end
    endtask

    // Reference model: pushes one expected {led, cfg_update, mode} per edge or reset.
    initial forever begin
        logic acc, all_eq, led_e;
        @(posedge clk25 or negedge fpga_rst_n);
        if (!fpga_rst_n) begin
            n_m = 0; active_m = 16'h0000; acc_m = 0; exp_led_m = 1'b0;
            hist.delete(); hist.push_back(16'h0000);
            exp_q.delete(); exp_q.push_back(4'b0000);
        end else begin
            n_m++;
            led_e = led_ref(active_m, acc_m, n_m);
            hist.push_back(usr_reg);
            if (hist.size() > S + 1) void'(hist.pop_front());
            acc = 1'b0;
            if (hist.size() == S + 1) begin
                all_eq = 1'b1;
                foreach (hist[i]) if (hist[i] != usr_reg) all_eq = 1'b0;
                acc = all_eq && (usr_reg != active_m);
            end
            if (acc) begin
                active_m = usr_reg;
                acc_m = n_m;
            end
            exp_q.push_back({led_e, acc, active_m[15:14]});
            exp_led_m = led_e;
        end
    end

    // Monitor: compares DUT outputs against the oldest expectation, away from the clock edge.
    initial forever begin
        logic [3:0] e;
        @(negedge clk25 or negedge fpga_rst_n);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({led_out, cfg_update, mode_o} !== e) begin
                n_fail++;
                $display("FAIL outputs edge %0d: led/cfg/mode got %b/%b/%b expected %b/%b/%b",
                         n_m, led_out, cfg_update, mode_o, e[3], e[2], e[1:0]);
            end
        end
    end

    task automatic hold(input logic [15:0] v, input int cycles);
        usr_reg = v;
        repeat (cycles) @(negedge clk25);
    endtask

    // Stimulus sequence covering the specified tests plus randomized configurations.
    initial begin
        logic [1:0] md;
        logic [5:0] dt;
        logic [7:0] hp;
        logic       found;
        #2 fpga_rst_n = 1'b0;
        check_reset_state("initial");
        repeat (3) @(negedge clk25);
        #3 fpga_rst_n = 1'b1;
        @(negedge clk25);
        hold(16'h4000, 10);
        hold(16'h7F00, 30);
        hold(16'h6000, 140);
        for (int i = 0; i < 25; i++) begin
            hold(16'h4100, 2);
            hold(16'h8105, 2);
        end
        hold(16'h6000, 70);
        hold(16'hBF02, 100);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_led_m) begin
                found = 1'b1;
                break;
            end
            @(negedge clk25);
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait expired: led_out never lit in BLINK before mid-pattern reset");
        end
        #3 fpga_rst_n = 1'b0;
        check_reset_state("mid-pattern");
        repeat (2) @(negedge clk25);
        #3 fpga_rst_n = 1'b1;
        hold(16'hBF02, 90);
        hold(16'hC401, 160);
        hold(16'hC401, 5);
        for (int i = 0; i < 50; i++) begin
            md = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       dt = 6'd0;
                1:       dt = 6'd63;
                default: dt = 6'($urandom_range(0, 63));
            endcase
            hp = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                hold({md, dt, hp}, $urandom_range(1, 6));
            else
                hold({md, dt, hp}, $urandom_range(30, 150));
        end
        repeat (4) @(negedge clk25);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
